// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions for the fetch stage and its instruction queue.
package cpu_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic {
        ISSUE = 1'b0,
        WAIT  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Cache read port and decode-side queue port of the fetch stage.
interface fetch_ic_if;
    logic [31:0] ic_addr;
    logic        ic_read_req;
    logic [31:0] ic_data;
    logic        ic_ready;

    modport master (output ic_addr, ic_read_req, input ic_data, ic_ready);
    modport slave  (input ic_addr, ic_read_req, output ic_data, ic_ready);
endinterface

interface fetch_dec_if;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        dec_ready;

    modport master (output dec_valid, dec_instr, dec_pc, input dec_ready);
    modport slave  (input dec_valid, dec_instr, dec_pc, output dec_ready);
endinterface

// File: rtl/fetch_fifo.sv
// Show-ahead synchronous FIFO of fetch entries; flush wins over push and pop.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  fetch_entry_t wdata_i,
    output fetch_entry_t rdata_o,
    output logic         full_o,
    output logic         empty_o,
    output logic [AW:0]  count_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A push at full is only accepted when the head leaves the same cycle.
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues single outstanding cache reads,
// and queues {pc, instr} for decode; redirects flush and drop stale data.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    fetch_ic_if.master         ic,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    fetch_dec_if.master        dec
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    fetch_state_t state_q;
    logic [31:0]  pc_q, addr_q;
    logic         req_q, discard_q;

    logic         fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0] fifo_cnt;
    fetch_entry_t fifo_wdata, fifo_rdata;
    logic         redirect_lsb_unused;

    assign redirect_lsb_unused = ^redirect_pc[1:0];

    assign ic.ic_addr     = addr_q;
    assign ic.ic_read_req = req_q;

    // In WAIT without discard the outstanding address is always pc_q.
    assign fifo_push  = (state_q == WAIT) && ic.ic_ready && !discard_q
                        && !redirect_valid && !fifo_full;
    assign fifo_pop   = dec.dec_valid && dec.dec_ready;
    assign fifo_wdata = '{pc: pc_q, instr: ic.ic_data};

    assign dec.dec_valid = !fifo_empty;
    assign dec.dec_instr = fifo_rdata.instr;
    assign dec.dec_pc    = fifo_rdata.pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ISSUE;
            pc_q      <= RESET_PC;
            addr_q    <= RESET_PC;
            req_q     <= 1'b0;
            discard_q <= 1'b0;
        end else begin
            req_q <= 1'b0;
            if (redirect_valid) begin
                pc_q <= {redirect_pc[31:2], 2'b00};
                // A response still in flight must be swallowed before reissuing.
                if (state_q == WAIT && !ic.ic_ready) begin
                    discard_q <= 1'b1;
                end else begin
                    discard_q <= 1'b0;
                    state_q   <= ISSUE;
                end
            end else begin
                case (state_q)
                    ISSUE: begin
                        if (fifo_cnt < DEPTH_C) begin
                            req_q   <= 1'b1;
                            addr_q  <= pc_q;
                            state_q <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (ic.ic_ready) begin
                            state_q <= ISSUE;
                            if (discard_q) discard_q <= 1'b0;
                            else           pc_q      <= pc_q + 32'd4;
                        end
                    end
                    default: state_q <= ISSUE;
                endcase
            end
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .flush_i (redirect_valid),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Fetch unit bench: variable-latency cache model, decode stream scoreboard.
module tb_fetch_unit;
    import cpu_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    fetch_ic_if  ic_bus ();
    fetch_dec_if dec_bus ();

    fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .ic             (ic_bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec            (dec_bus)
    );

    int          checks = 0, errors = 0, pops = 0;
    logic [31:0] exp_q[$];
    logic [31:0] req_log[$];
    int          lat_fixed = 2;
    bit          busy = 1'b0;
    logic [31:0] req_addr;
    int          lat_cnt;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural expectation: decode sees start, start+4, ... until the next redirect.
    task automatic seed(input logic [31:0] start);
        exp_q.delete();
        for (int k = 0; k < 256; k++) exp_q.push_back(start + 32'(4 * k));
    endtask

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic redirect(input logic [31:0] t);
        redirect_valid = 1'b1;
        redirect_pc    = t;
        seed({t[31:2], 2'b00});
        req_log.delete();
        cyc(1);
        redirect_valid = 1'b0;
    endtask

    task automatic wait_pops(input int target, input int budget, input string name);
        int c = 0;
        while (pops < target && c < budget) begin cyc(1); c++; end
        chk(name, 32'(pops >= target), 32'd1);
    endtask

    task automatic wait_reqs(input int n, input int budget, input string name);
        int c = 0;
        while (req_log.size() < n && c < budget) begin cyc(1); c++; end
        chk(name, 32'(req_log.size() >= n), 32'd1);
    endtask

    task automatic chk_req(input string name, input int idx, input logic [31:0] exp);
        if (req_log.size() > idx) chk(name, req_log[idx], exp);
        else chk(name, 32'hDEAD_BEEF, exp);
    endtask

    // Cache model: one outstanding read, response after lat_cnt cycles.
    initial begin
        ic_bus.ic_ready = 1'b0;
        ic_bus.ic_data  = '0;
        forever begin
            @(posedge clk); #1;
            ic_bus.ic_ready = 1'b0;
            if (!reset) begin
                busy = 1'b0;
                continue;
            end
            if (busy) begin
                chk("addr_stable", ic_bus.ic_addr, req_addr);
                chk("single_outstanding", 32'(ic_bus.ic_read_req), 32'd0);
                lat_cnt--;
                if (lat_cnt == 0) begin
                    ic_bus.ic_ready = 1'b1;
                    ic_bus.ic_data  = mem_word(req_addr);
                    busy = 1'b0;
                end
            end else if (ic_bus.ic_read_req) begin
                chk("addr_aligned", 32'(ic_bus.ic_addr[1:0]), 32'd0);
                req_addr = ic_bus.ic_addr;
                req_log.push_back(ic_bus.ic_addr);
                busy    = 1'b1;
                lat_cnt = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(2, 6));
            end
        end
    end

    // Scoreboard monitor: every accepted head must match the expected stream.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (reset && dec_bus.dec_valid && dec_bus.dec_ready && !redirect_valid) begin
                pops++;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL stream_underflow: got pc %h expected none", dec_bus.dec_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("dec_pc", dec_bus.dec_pc, e);
                    chk("dec_instr", dec_bus.dec_instr, mem_word(e));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p, c;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        dec_bus.dec_ready = 1'b0;
        #2 reset = 1'b0;
        seed(RST_PC);
        cyc(3);
        chk("rst_req", 32'(ic_bus.ic_read_req), 32'd0);
        chk("rst_addr", ic_bus.ic_addr, RST_PC);
        chk("rst_valid", 32'(dec_bus.dec_valid), 32'd0);
        chk("rst_instr", dec_bus.dec_instr, 32'd0);
        chk("rst_pc", dec_bus.dec_pc, 32'd0);
        reset = 1'b1;

        // Sequential fetch from reset
        dec_bus.dec_ready = 1'b1;
        wait_reqs(3, 40, "seq_reqs");
        chk_req("seq_req0", 0, 32'h0);
        chk_req("seq_req1", 1, 32'h4);
        chk_req("seq_req2", 2, 32'h8);
        wait_pops(3, 40, "seq_pops");

        // Backpressure: fill, then a single pop frees one slot
        dec_bus.dec_ready = 1'b0;
        redirect(32'h40);
        cyc(40);
        chk("bp_req_count", 32'(req_log.size()), 32'd4);
        for (int k = 0; k < 4; k++) chk_req("bp_req", k, 32'h40 + 32'(4 * k));
        chk("bp_full_valid", 32'(dec_bus.dec_valid), 32'd1);
        p = pops;
        dec_bus.dec_ready = 1'b1;
        cyc(1);
        dec_bus.dec_ready = 1'b0;
        chk("bp_one_pop", 32'(pops - p), 32'd1);
        wait_reqs(5, 20, "bp_refill");
        chk_req("bp_req4", 4, 32'h50);

        // Redirect while a slow request is outstanding
        lat_fixed = 10;
        dec_bus.dec_ready = 1'b1;
        redirect(32'h20);
        c = 0;
        while (!(busy && req_addr == 32'h20) && c < 100) begin cyc(1); c++; end
        chk("miss_outstanding", 32'(busy && req_addr == 32'h20), 32'd1);
        cyc(3);
        redirect(32'h100);
        wait_reqs(1, 40, "miss_reissue");
        chk_req("miss_req", 0, 32'h100);
        wait_pops(pops + 1, 60, "miss_pop");

        // Redirect coinciding with a response and a pop, two entries queued
        lat_fixed = 2;
        dec_bus.dec_ready = 1'b0;
        redirect(32'h300);
        c = 0;
        while (!(ic_bus.ic_ready && req_addr == 32'h308) && c < 100) begin cyc(1); c++; end
        chk("coll_two_valid", 32'(dec_bus.dec_valid), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        dec_bus.dec_ready = 1'b1;
        seed(32'h200);
        req_log.delete();
        cyc(1);
        redirect_valid = 1'b0;
        dec_bus.dec_ready = 1'b0;
        chk("coll_flushed", 32'(dec_bus.dec_valid), 32'd0);
        wait_reqs(1, 20, "coll_reissue");
        chk_req("coll_req", 0, 32'h200);
        dec_bus.dec_ready = 1'b1;
        wait_pops(pops + 1, 30, "coll_pop");

        // PC wrap at the top of the address space
        lat_fixed = 0;
        redirect(32'hFFFF_FFF8);
        wait_reqs(3, 60, "wrap_reqs");
        chk_req("wrap_req0", 0, 32'hFFFF_FFF8);
        chk_req("wrap_req1", 1, 32'hFFFF_FFFC);
        chk_req("wrap_req2", 2, 32'h0000_0000);
        wait_pops(pops + 3, 60, "wrap_pops");

        // Randomized traffic
        p = pops;
        for (int i = 0; i < 1500; i++) begin
            dec_bus.dec_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) redirect($urandom);
            else cyc(1);
        end
        chk("rand_progress", 32'(pops - p > 60), 32'd1);

        // Asynchronous reset between edges while waiting on the cache
        lat_fixed = 8;
        dec_bus.dec_ready = 1'b1;
        c = 0;
        while (!busy && c < 50) begin cyc(1); c++; end
        chk("arst_busy", 32'(busy), 32'd1);
        @(posedge clk); #3;
        reset = 1'b0;
        seed(RST_PC);
        req_log.delete();
        #1;
        chk("arst_req", 32'(ic_bus.ic_read_req), 32'd0);
        chk("arst_addr", ic_bus.ic_addr, RST_PC);
        chk("arst_valid", 32'(dec_bus.dec_valid), 32'd0);
        chk("arst_instr", dec_bus.dec_instr, 32'd0);
        chk("arst_pc", dec_bus.dec_pc, 32'd0);
        cyc(2);
        lat_fixed = 2;
        reset = 1'b1;
        wait_reqs(1, 20, "arst_reissue");
        chk_req("arst_first_req", 0, RST_PC);
        wait_pops(pops + 2, 60, "arst_pops");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
